// File: rtl/dff_debounce_edge.sv
// -----------------------------------------------------------------------------
// dff_debounce_edge
//
// Input conditioning for the downstream asynchronous-reset D flip-flop stage.
// It synchronizes the raw asynchronous level `data` into the clk domain and
// debounces it. It then presents the clean level `q` together with one-cycle
// `rise`/`fall` pulses. All outputs come straight from flops.
//
// Parameters
//   SYNC_STAGES      synchronizer depth (>= 2)
//   DEBOUNCE_CYCLES  consecutive cycles of a new level needed to accept it (>= 1)
//   CNT_W            width of the optional edge counter (>= 1)
//
// Ports
//   clk       in   single clock, rising edge
//   reset     in   asynchronous, active-low reset
//   data      in   raw asynchronous level
//   q         out  debounced, synchronized level
//   rise      out  one-cycle pulse on q 0->1
//   fall      out  one-cycle pulse on q 1->0
//   cnt_clr   in   synchronous clear of edge_cnt        (macro only)
//   edge_cnt  out  count of accepted transitions, wraps (macro only)
//
// Build option
//   `define DFF_DEBOUNCE_EDGE_CNT_EN to build cnt_clr/edge_cnt. When the macro
//   is undefined, neither port nor any counter logic exists.
// -----------------------------------------------------------------------------
module dff_debounce_edge #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data,
`ifdef DFF_DEBOUNCE_EDGE_CNT_EN
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] edge_cnt,
`endif
    output logic             q,
    output logic             rise,
    output logic             fall
);

    // Stability counter width: max(1, clog2(DEBOUNCE_CYCLES)).
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DONE  = DW'(1);

    // Parameter legality, checked at elaboration.
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("dff_debounce_edge: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_chk_deb
        $error("dff_debounce_edge: DEBOUNCE_CYCLES must be >= 1");
    end
    if (CNT_W < 1) begin : g_chk_cnt
        $error("dff_debounce_edge: CNT_W must be >= 1");
    end

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [DW-1:0]          dcnt_q;
    logic [DW-1:0]          dcnt_d;
    logic                   q_d;
    logic                   rise_d;
    logic                   fall_d;
    logic                   accept;

    // ------------------------------------------------------------------
    // Synchronizer: plain shift chain, nothing between the flops.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], data};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce FSM: state register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= STABLE;
            dcnt_q  <= '0;
            q       <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            q       <= q_d;
            rise    <= rise_d;
            fall    <= fall_d;
        end
    end

    // ------------------------------------------------------------------
    // Debounce FSM: next state and outputs.
    // dcnt holds the number of mismatch edges already seen. The edge that
    // leaves STABLE counts as the first one, so it loads 1. Acceptance
    // therefore happens on the DEBOUNCE_CYCLES-th consecutive mismatch edge,
    // which is when dcnt == DEBOUNCE_CYCLES-1 in CHECK. With a single-cycle
    // debounce the first mismatch is accepted straight from STABLE.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        accept  = 1'b0;

        case (state_q)
            STABLE: begin
                dcnt_d = '0;
                if (s != q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        accept = 1'b1;
                    end else begin
                        state_d = CHECK;
                        dcnt_d  = DONE;
                    end
                end
            end

            CHECK: begin
                if (s == q) begin
                    // Glitch: level went back before it was accepted.
                    state_d = STABLE;
                    dcnt_d  = '0;
                end else if (dcnt_q == DLAST) begin
                    accept  = 1'b1;
                    state_d = STABLE;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end

            default: begin
                state_d = STABLE;
                dcnt_d  = '0;
            end
        endcase

        q_d    = accept ? s : q;
        rise_d = accept & s;
        fall_d = accept & ~s;
    end

`ifdef DFF_DEBOUNCE_EDGE_CNT_EN
    // ------------------------------------------------------------------
    // Edge-event counter: counts registered pulses, so it trails them by
    // one edge. A clear wins over a coincident increment.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_cnt <= '0;
        end else if (cnt_clr) begin
            edge_cnt <= '0;
        end else if (rise || fall) begin
            edge_cnt <= edge_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dff_debounce_edge.sv
// -----------------------------------------------------------------------------
// tb_dff_debounce_edge
//
// Directed bench for dff_debounce_edge. Instance u0 uses default parameters.
// Instance u1 uses DEBOUNCE_CYCLES=1 and CNT_W=2, for the single-cycle and
// counter-wrap cases. Counter checks exist only when
// DFF_DEBOUNCE_EDGE_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_dff_debounce_edge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic data0, q0, rise0, fall0;
    logic data1, q1, rise1, fall1;
`ifdef DFF_DEBOUNCE_EDGE_CNT_EN
    logic       clr0, clr1;
    logic [7:0] ec0;
    logic [1:0] ec1;
`endif

    int total = 0;
    int bad   = 0;

    dff_debounce_edge #(
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(8)
    ) u0 (
        .clk(clk),
        .reset(rst_n),
        .data(data0),
`ifdef DFF_DEBOUNCE_EDGE_CNT_EN
        .cnt_clr(clr0),
        .edge_cnt(ec0),
`endif
        .q(q0),
        .rise(rise0),
        .fall(fall0)
    );

    dff_debounce_edge #(
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(1),
        .CNT_W(2)
    ) u1 (
        .clk(clk),
        .reset(rst_n),
        .data(data1),
`ifdef DFF_DEBOUNCE_EDGE_CNT_EN
        .cnt_clr(clr1),
        .edge_cnt(ec1),
`endif
        .q(q1),
        .rise(rise1),
        .fall(fall1)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges; sample 1 unit after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        data0 = 1'b1;
        data1 = 1'b0;
`ifdef DFF_DEBOUNCE_EDGE_CNT_EN
        clr0 = 1'b0;
        clr1 = 1'b0;
`endif

        // Reset held 3 cycles with data0=1.
        step(3);
        chk1("rst_q", q0, 1'b0);
        chk1("rst_rise", rise0, 1'b0);
        chk1("rst_fall", fall0, 1'b0);
`ifdef DFF_DEBOUNCE_EDGE_CNT_EN
        chkn("rst_cnt", 32'(ec0), 0);
`endif

        // Release: q rises at the 6th edge, with one rise pulse.
        rst_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step(1);
            chk1("rel_q", q0, i >= 6);
            chk1("rel_rise", rise0, i == 6);
        end
        chk1("rel_q1_idle", q1, 1'b0);
`ifdef DFF_DEBOUNCE_EDGE_CNT_EN
        chkn("rel_cnt", 32'(ec0), 1);
`endif

        // Settle low, then clear the counter.
        data0 = 1'b0;
        step(8);
        chk1("settle_q", q0, 1'b0);
`ifdef DFF_DEBOUNCE_EDGE_CNT_EN
        clr0 = 1'b1;
        step(1);
        clr0 = 1'b0;
        chkn("clr_cnt", 32'(ec0), 0);
`endif

        // Clean step 0->1.
        data0 = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step(1);
            chk1("up_q", q0, i >= 6);
            chk1("up_rise", rise0, i == 6);
            chk1("up_fall", fall0, 1'b0);
        end
`ifdef DFF_DEBOUNCE_EDGE_CNT_EN
        chkn("up_cnt", 32'(ec0), 1);
`endif

        // 20 cycles after the rise input, step 1->0.
        step(13);
        data0 = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step(1);
            chk1("dn_q", q0, i < 6);
            chk1("dn_fall", fall0, i == 6);
            chk1("dn_rise", rise0, 1'b0);
        end
`ifdef DFF_DEBOUNCE_EDGE_CNT_EN
        chkn("dn_cnt", 32'(ec0), 2);
`endif

        // 3-cycle glitch is rejected.
        step(4);
        data0 = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            if (i == 3) data0 = 1'b0;
            chk1("g3_q", q0, 1'b0);
            chk1("g3_rise", rise0, 1'b0);
            chk1("g3_fall", fall0, 1'b0);
        end
`ifdef DFF_DEBOUNCE_EDGE_CNT_EN
        chkn("g3_cnt", 32'(ec0), 2);
`endif

        // 4-cycle pulse is accepted: q high after edges 6..9.
        data0 = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            if (i == 4) data0 = 1'b0;
            chk1("g4_q", q0, (i >= 6) && (i <= 9));
            chk1("g4_rise", rise0, i == 6);
            chk1("g4_fall", fall0, i == 10);
        end
`ifdef DFF_DEBOUNCE_EDGE_CNT_EN
        chkn("g4_cnt", 32'(ec0), 4);
`endif

        // Async reset one cycle before acceptance.
        step(4);
        data0 = 1'b1;
        step(5);
        chk1("mid_pre_q", q0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk1("mid_async_q", q0, 1'b0);
        chk1("mid_async_rise", rise0, 1'b0);
`ifdef DFF_DEBOUNCE_EDGE_CNT_EN
        chkn("mid_async_cnt", 32'(ec0), 0);
`endif
        step(1);
        chk1("mid_hold_q", q0, 1'b0);
        chk1("mid_hold_rise", rise0, 1'b0);
        // Release with data0 still high: full latency proves the chain was cleared.
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step(1);
            chk1("mid_rel_q", q0, i == 6);
            chk1("mid_rel_rise", rise0, i == 6);
        end

        // DEBOUNCE_CYCLES=1: single-cycle data pulse.
        data1 = 1'b1;
        step(1);
        data1 = 1'b0;
        step(1);
        chk1("d1_q_e2", q1, 1'b0);
        step(1);
        chk1("d1_q_e3", q1, 1'b1);
        chk1("d1_rise_e3", rise1, 1'b1);
        chk1("d1_fall_e3", fall1, 1'b0);
        step(1);
        chk1("d1_q_e4", q1, 1'b0);
        chk1("d1_fall_e4", fall1, 1'b1);
        chk1("d1_rise_e4", rise1, 1'b0);
        step(1);
        chk1("d1_fall_e5", fall1, 1'b0);

`ifdef DFF_DEBOUNCE_EDGE_CNT_EN
        // Counter wrap with CNT_W=2.
        clr1 = 1'b1;
        step(1);
        clr1 = 1'b0;
        chkn("wrap_clr", 32'(ec1), 0);
        for (int t = 1; t <= 5; t++) begin
            data1 = ~data1;
            step(4);
            chkn("wrap_cnt", 32'(ec1), 32'(t % 4));
        end

        // Clear coinciding with a pulse wins.
        data1 = ~data1;
        step(3);
        chk1("coin_pulse", rise1 | fall1, 1'b1);
        clr1 = 1'b1;
        step(1);
        clr1 = 1'b0;
        chkn("coin_cnt", 32'(ec1), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
